gpio_edge_subunit7: RTL and testbench

//  Parametrised GPIO pin bank: configurable width, per-pin interrupt type (level/edge),

---
 rtl/gpio_edge_subunit7_pkg.sv | 35 +++
 rtl/gpio_edge_subunit7_debounce.sv | 59 +++++
 rtl/gpio_edge_subunit7.sv | 138 +++++++++++++
 tb/tb_gpio_edge_subunit7.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_edge_subunit7_pkg.sv
// Shared constants for the GPIO edge subunit: register map, reset values,
// interrupt type / polarity encodings and the per-pin event rule.
package gpio_pkg7;

    localparam logic [7:0] A_DIR    = 8'h04;
    localparam logic [7:0] A_OE     = 8'h08;
    localparam logic [7:0] A_OUT    = 8'h0C;
    localparam logic [7:0] A_IN     = 8'h10;
    localparam logic [7:0] A_MASK   = 8'h14;
    localparam logic [7:0] A_TYPE   = 8'h18;
    localparam logic [7:0] A_POL    = 8'h1C;
    localparam logic [7:0] A_STATUS = 8'h20;
    localparam logic [7:0] A_BOTH   = 8'h24;
    localparam logic [7:0] A_DBP    = 8'h28;

    localparam logic REG_RST_BIT  = 1'b0;
    localparam logic OE_N_RST_BIT = 1'b1;

    localparam logic TYPE_EDGE  = 1'b0;
    localparam logic TYPE_LEVEL = 1'b1;
    localparam logic POL_LOW    = 1'b0;
    localparam logic POL_HIGH   = 1'b1;
    localparam logic DIR_OUT    = 1'b0;
    localparam logic DIR_IN     = 1'b1;

    // One pin's event from current / previous filtered input.
    function automatic logic pin_event(input logic cur, input logic prev,
                                       input logic typ, input logic pol,
                                       input logic both);
        if (typ == TYPE_LEVEL) return cur == pol;
        if (both)              return cur ^ prev;
        return (cur ^ prev) & (cur == pol);
    endfunction

endpackage

// File: rtl/gpio_edge_subunit7_debounce.sv
// Input conditioning: two-flop synchroniser, prescaler and per-pin two-tick
// agreement filter. A zero period bypasses the filter.
module gpio_debounce7
    import gpio_pkg7::*;
#(
    parameter int GPIO_WIDTH = 16,
    parameter int DB_WIDTH   = 8
) (
    input  logic                  pclk7,
    input  logic                  n_reset7,
    input  logic [GPIO_WIDTH-1:0] i_pin,
    input  logic [DB_WIDTH-1:0]   i_dbp,
    input  logic                  i_dbp_wr,
    output logic [GPIO_WIDTH-1:0] o_filt
);

    logic [GPIO_WIDTH-1:0] r_sync1, r_sync2, r_last, r_filt;
    logic [DB_WIDTH-1:0]   r_cnt;
    logic                  w_bypass, w_tick;

    assign w_bypass = (i_dbp == '0);
    assign w_tick   = !w_bypass && (r_cnt == i_dbp);
    assign o_filt   = w_bypass ? r_sync2 : r_filt;

    always_ff @(posedge pclk7 or negedge n_reset7) begin
        if (!n_reset7) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge pclk7 or negedge n_reset7) begin
        if (!n_reset7)                           r_cnt <= '0;
        else if (i_dbp_wr || w_tick || w_bypass) r_cnt <= '0;
        else                                     r_cnt <= r_cnt + 1'b1;
    end

    // In bypass the filter tracks the synchroniser so enabling it starts clean.
    always_ff @(posedge pclk7 or negedge n_reset7) begin
        if (!n_reset7) begin
            r_last <= '0;
            r_filt <= '0;
        end else begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                if (w_bypass) begin
                    r_last[i] <= r_sync2[i];
                    r_filt[i] <= r_sync2[i];
                end else if (w_tick) begin
                    r_last[i] <= r_sync2[i];
                    if (r_sync2[i] == r_last[i]) r_filt[i] <= r_sync2[i];
                end
            end
        end
    end

endmodule

// File: rtl/gpio_edge_subunit7.sv
// GPIO pin bank: register file, edge/level event detection, W1C status,
// masked interrupts, registered read mux and pad control.
module gpio_edge_subunit7
    import gpio_pkg7::*;
#(
    parameter int GPIO_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int DB_WIDTH   = 8
) (
    input  logic                  pclk7,
    input  logic                  n_reset7,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [GPIO_WIDTH-1:0] wdata7,
    input  logic [GPIO_WIDTH-1:0] pin_in7,
    input  logic [GPIO_WIDTH-1:0] tri_state_enable7,
    output logic [GPIO_WIDTH-1:0] rdata7,
    output logic [GPIO_WIDTH-1:0] pin_out7,
    output logic [GPIO_WIDTH-1:0] pin_oe_n7,
    output logic [GPIO_WIDTH-1:0] interrupt7,
    output logic                  irq_any7
);

    localparam logic [ADDR_WIDTH-1:0] L_DIR    = ADDR_WIDTH'(A_DIR);
    localparam logic [ADDR_WIDTH-1:0] L_OE     = ADDR_WIDTH'(A_OE);
    localparam logic [ADDR_WIDTH-1:0] L_OUT    = ADDR_WIDTH'(A_OUT);
    localparam logic [ADDR_WIDTH-1:0] L_IN     = ADDR_WIDTH'(A_IN);
    localparam logic [ADDR_WIDTH-1:0] L_MASK   = ADDR_WIDTH'(A_MASK);
    localparam logic [ADDR_WIDTH-1:0] L_TYPE   = ADDR_WIDTH'(A_TYPE);
    localparam logic [ADDR_WIDTH-1:0] L_POL    = ADDR_WIDTH'(A_POL);
    localparam logic [ADDR_WIDTH-1:0] L_STATUS = ADDR_WIDTH'(A_STATUS);
    localparam logic [ADDR_WIDTH-1:0] L_BOTH   = ADDR_WIDTH'(A_BOTH);
    localparam logic [ADDR_WIDTH-1:0] L_DBP    = ADDR_WIDTH'(A_DBP);
    localparam int DBN = (DB_WIDTH < GPIO_WIDTH) ? DB_WIDTH : GPIO_WIDTH;

    logic [GPIO_WIDTH-1:0] r_dir, r_oe, r_out, r_mask, r_type, r_pol, r_both;
    logic [GPIO_WIDTH-1:0] r_in, r_in_prev, r_status, r_rdata;
    logic [DB_WIDTH-1:0]   r_dbp;
    logic [GPIO_WIDTH-1:0] w_filt, w_event, w_clr, w_rmux, w_rdbp;
    logic [DB_WIDTH-1:0]   w_wdbp;
    logic                  w_dbp_wr;

    assign w_dbp_wr = write && (addr == L_DBP);

    gpio_debounce7 #(.GPIO_WIDTH(GPIO_WIDTH), .DB_WIDTH(DB_WIDTH)) u_db (
        .pclk7    (pclk7),
        .n_reset7 (n_reset7),
        .i_pin    (pin_in7),
        .i_dbp    (r_dbp),
        .i_dbp_wr (w_dbp_wr),
        .o_filt   (w_filt)
    );

    always_comb begin
        w_wdbp = '0;
        w_wdbp[DBN-1:0] = wdata7[DBN-1:0];
        w_rdbp = '0;
        w_rdbp[DBN-1:0] = r_dbp[DBN-1:0];
    end

    always_ff @(posedge pclk7 or negedge n_reset7) begin
        if (!n_reset7) begin
            r_dir  <= '0;
            r_oe   <= '0;
            r_out  <= '0;
            r_mask <= '0;
            r_type <= '0;
            r_pol  <= '0;
            r_both <= '0;
            r_dbp  <= '0;
        end else if (write) begin
            case (addr)
                L_DIR:   r_dir  <= wdata7;
                L_OE:    r_oe   <= wdata7;
                L_OUT:   r_out  <= wdata7;
                L_MASK:  r_mask <= wdata7;
                L_TYPE:  r_type <= wdata7;
                L_POL:   r_pol  <= wdata7;
                L_BOTH:  r_both <= wdata7;
                L_DBP:   r_dbp  <= w_wdbp;
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk7 or negedge n_reset7) begin
        if (!n_reset7) begin
            r_in      <= '0;
            r_in_prev <= '0;
        end else begin
            r_in      <= w_filt;
            r_in_prev <= r_in;
        end
    end

    always_comb begin
        w_event = '0;
        for (int i = 0; i < GPIO_WIDTH; i++)
            w_event[i] = pin_event(r_in[i], r_in_prev[i], r_type[i], r_pol[i], r_both[i]);
    end

    // Set is OR-ed after the clear so a coincident event wins.
    assign w_clr = (write && addr == L_STATUS) ? wdata7 : '0;

    always_ff @(posedge pclk7 or negedge n_reset7) begin
        if (!n_reset7) r_status <= '0;
        else           r_status <= (r_status & ~w_clr) | (w_event & r_dir);
    end

    always_comb begin
        case (addr)
            L_DIR:    w_rmux = r_dir;
            L_OE:     w_rmux = r_oe;
            L_OUT:    w_rmux = r_out;
            L_IN:     w_rmux = r_in;
            L_MASK:   w_rmux = r_mask;
            L_TYPE:   w_rmux = r_type;
            L_POL:    w_rmux = r_pol;
            L_STATUS: w_rmux = r_status;
            L_BOTH:   w_rmux = r_both;
            L_DBP:    w_rmux = w_rdbp;
            default:  w_rmux = '0;
        endcase
    end

    always_ff @(posedge pclk7 or negedge n_reset7) begin
        if (!n_reset7) r_rdata <= '0;
        else           r_rdata <= read ? w_rmux : '0;
    end

    assign rdata7     = r_rdata;
    assign pin_out7   = r_out;
    assign pin_oe_n7  = ~(r_oe & ~r_dir) | tri_state_enable7;
    assign interrupt7 = r_status & r_mask;
    assign irq_any7   = |interrupt7;

endmodule

// File: tb/tb_gpio_edge_subunit7.sv
// Bench for gpio_edge_subunit7: register table, directed corner sequences and
// a randomized phase checked against a delay-line reference model.
module tb_gpio_edge_subunit7;

    localparam int W  = 16;
    localparam int AW = 6;

    localparam logic [AW-1:0] A_DIR = 6'h04, A_OE = 6'h08, A_OUT = 6'h0C, A_IN = 6'h10,
                              A_MASK = 6'h14, A_TYPE = 6'h18, A_POL = 6'h1C,
                              A_STATUS = 6'h20, A_BOTH = 6'h24, A_DBP = 6'h28, A_UNM = 6'h2C;

    logic          pclk7 = 1'b0, n_reset7 = 1'b0, read = 1'b0, write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [W-1:0]  wdata7 = '0, pin_in7 = '0, tse = '0;
    logic [W-1:0]  rdata7, pin_out7, pin_oe_n7, interrupt7;
    logic          irq_any7;

    int n_chk = 0, n_pass = 0;

    always #5 pclk7 = ~pclk7;

    gpio_edge_subunit7 #(.GPIO_WIDTH(16), .ADDR_WIDTH(6), .DB_WIDTH(8)) dut (
        .pclk7             (pclk7),
        .n_reset7          (n_reset7),
        .read              (read),
        .write             (write),
        .addr              (addr),
        .wdata7            (wdata7),
        .pin_in7           (pin_in7),
        .tri_state_enable7 (tse),
        .rdata7            (rdata7),
        .pin_out7          (pin_out7),
        .pin_oe_n7         (pin_oe_n7),
        .interrupt7        (interrupt7),
        .irq_any7          (irq_any7)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  wd;
        logic [W-1:0]  exp;
    } vec_t;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk7);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        addr = a; wdata7 = d; write = 1'b1;
        @(negedge pclk7);
        write = 1'b0; wdata7 = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [W-1:0] d);
        addr = a; read = 1'b1;
        @(negedge pclk7);
        read = 1'b0;
        d = rdata7;
    endtask

    task automatic do_reset();
        n_reset7 = 1'b0; read = 1'b0; write = 1'b0; pin_in7 = '0; tse = '0;
        tick(2);
        n_reset7 = 1'b1;
    endtask

    function automatic logic [W-1:0] ref_event(input logic [W-1:0] cur, input logic [W-1:0] prv,
                                               input logic [W-1:0] typ, input logic [W-1:0] pol,
                                               input logic [W-1:0] both);
        logic [W-1:0] e;
        for (int i = 0; i < W; i++) begin
            if (typ[i])       e[i] = (cur[i] == pol[i]);
            else if (both[i]) e[i] = (cur[i] != prv[i]);
            else              e[i] = (cur[i] != prv[i]) && (cur[i] == pol[i]);
        end
        return e;
    endfunction

    logic [AW-1:0] all_regs [10];
    logic [AW-1:0] rnd_regs [10];
    vec_t          tbl [12];
    logic [W-1:0]  m_dir, m_oe, m_out, m_mask, m_type, m_pol, m_both, m_st;
    logic [W-1:0]  hist [5];

    initial begin
        logic [W-1:0] d, pin, rexp, ev, clr, cur, prv;
        logic [AW-1:0] a;
        int op, idx;

        all_regs = '{A_DIR, A_OE, A_OUT, A_IN, A_MASK, A_TYPE, A_POL, A_STATUS, A_BOTH, A_DBP};
        rnd_regs = '{A_DIR, A_OE, A_OUT, A_IN, A_MASK, A_TYPE, A_POL, A_STATUS, A_BOTH, A_UNM};
        tbl[0]  = '{A_DIR,  16'hFFFF, 16'hFFFF};
        tbl[1]  = '{A_OE,   16'h1234, 16'h1234};
        tbl[2]  = '{A_OUT,  16'hA5A5, 16'hA5A5};
        tbl[3]  = '{A_MASK, 16'h00F0, 16'h00F0};
        tbl[4]  = '{A_TYPE, 16'h0F0F, 16'h0F0F};
        tbl[5]  = '{A_POL,  16'h3C3C, 16'h3C3C};
        tbl[6]  = '{A_BOTH, 16'h8001, 16'h8001};
        tbl[7]  = '{A_DBP,  16'h01FF, 16'h00FF};
        tbl[8]  = '{A_IN,   16'h5A5A, 16'h0000};
        tbl[9]  = '{6'h00,  16'hFFFF, 16'h0000};
        tbl[10] = '{A_UNM,  16'hFFFF, 16'h0000};
        tbl[11] = '{6'h3F,  16'hFFFF, 16'h0000};

        // Reset state
        tick(2);
        n_reset7 = 1'b1;
        tick(1);
        chk("rst_oe_n", pin_oe_n7, 16'hFFFF);
        chk("rst_rdata", rdata7, '0);
        chk("rst_int", interrupt7, '0);
        chk("rst_irq_any", W'(irq_any7), '0);
        chk("rst_pin_out", pin_out7, '0);
        foreach (all_regs[i]) begin
            rd(all_regs[i], d);
            chk($sformatf("rst_reg_%h", all_regs[i]), d, '0);
        end

        // Register table: write then read back
        foreach (tbl[i]) begin
            wr(tbl[i].a, tbl[i].wd);
            rd(tbl[i].a, d);
            chk($sformatf("tbl_%0d_addr_%h", i, tbl[i].a), d, tbl[i].exp);
        end
        tick(1);
        chk("rdata_idle", rdata7, '0);

        // Pads
        do_reset();
        wr(A_DIR, 16'h0000); wr(A_OE, 16'hFFFF); wr(A_OUT, 16'hA5A5);
        chk("pad_out", pin_out7, 16'hA5A5);
        chk("pad_oe_n", pin_oe_n7, 16'h0000);
        tse = 16'h0001;
        #1 chk("pad_tse", pin_oe_n7, 16'h0001);
        tse = '0;

        // Rising edge, latency, W1C, falling ignored, any-edge
        do_reset();
        wr(A_DIR, 16'hFFFF); wr(A_MASK, 16'h0001); wr(A_TYPE, 16'h0000); wr(A_POL, 16'hFFFF);
        pin_in7 = 16'h0001;
        tick(3);
        chk("edge_lat_pre", interrupt7, '0);
        tick(1);
        chk("edge_lat_int", interrupt7, 16'h0001);
        chk("edge_irq_any", W'(irq_any7), 16'h0001);
        rd(A_STATUS, d); chk("edge_status", d, 16'h0001);
        wr(A_STATUS, 16'h0001);
        rd(A_STATUS, d); chk("edge_w1c", d, 16'h0000);
        pin_in7 = 16'h0000;
        tick(5);
        rd(A_STATUS, d); chk("edge_fall_ignored", d, 16'h0000);
        wr(A_BOTH, 16'h0001);
        pin_in7 = 16'h0001;
        tick(5);
        rd(A_STATUS, d); chk("both_rise", d, 16'h0001);
        wr(A_STATUS, 16'h0001);
        pin_in7 = 16'h0000;
        tick(5);
        rd(A_STATUS, d); chk("both_fall", d, 16'h0001);

        // Level source
        do_reset();
        wr(A_DIR, 16'hFFFF); wr(A_TYPE, 16'h0008); wr(A_POL, 16'hFFF7);
        tick(2);
        rd(A_STATUS, d); chk("level_set", d, 16'h0008);
        wr(A_STATUS, 16'h0008);
        tick(1);
        rd(A_STATUS, d); chk("level_reset", d, 16'h0008);
        pin_in7 = 16'h0008;
        tick(4);
        wr(A_STATUS, 16'h0008);
        tick(1);
        rd(A_STATUS, d); chk("level_gone", d, 16'h0000);

        // Debounce
        do_reset();
        wr(A_DBP, 16'h0004);
        pin_in7 = 16'h0004;
        tick(1);
        pin_in7 = 16'h0000;
        tick(15);
        rd(A_IN, d); chk("db_glitch", d, 16'h0000);
        pin_in7 = 16'h0004;
        tick(13);
        rd(A_IN, d); chk("db_held", d, 16'h0004);
        pin_in7 = 16'h0000;
        tick(4);
        #2 n_reset7 = 1'b0;
        @(negedge pclk7);
        n_reset7 = 1'b1;
        chk("db_rst_int", interrupt7, '0);
        rd(A_IN, d); chk("db_rst_in", d, 16'h0000);
        rd(A_DBP, d); chk("db_rst_dbp", d, 16'h0000);

        // Set wins over coincident clear; unmask of pending bit
        do_reset();
        wr(A_DIR, 16'hFFFF); wr(A_POL, 16'hFFFF);
        pin_in7 = 16'h0020;
        tick(3);
        wr(A_STATUS, 16'h0020);
        rd(A_STATUS, d); chk("same_cycle_set_wins", d, 16'h0020);
        chk("masked_pending", interrupt7, '0);
        wr(A_MASK, 16'h0020);
        chk("unmask_pending", interrupt7, 16'h0020);
        wr(A_STATUS, 16'h0020);
        rd(A_STATUS, d); chk("w1c_after", d, 16'h0000);
        wr(6'h3C, 16'hFFFF);
        rd(6'h3C, d); chk("unmapped_rd", d, 16'h0000);

        // Randomized phase against the reference model (DBP stays 0)
        do_reset();
        {m_dir, m_oe, m_out, m_mask, m_type, m_pol, m_both, m_st} = '0;
        foreach (hist[i]) hist[i] = '0;
        pin = '0;
        for (int k = 0; k < 600; k++) begin
            op = $urandom_range(0, 3);
            a  = rnd_regs[$urandom_range(0, 9)];
            d  = W'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, W - 1);
                pin[idx] = ~pin[idx];
            end
            if ($urandom_range(0, 7) == 0) tse = W'($urandom);
            pin_in7 = pin; addr = a; wdata7 = d;
            write = (op == 1); read = (op == 2);
            @(posedge pclk7);
            // Input seen at edge k becomes IN three edges later
            for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = pin;
            cur = hist[3];
            prv = hist[4];
            rexp = '0;
            if (op == 2) begin
                case (a)
                    A_DIR:    rexp = m_dir;
                    A_OE:     rexp = m_oe;
                    A_OUT:    rexp = m_out;
                    A_IN:     rexp = cur;
                    A_MASK:   rexp = m_mask;
                    A_TYPE:   rexp = m_type;
                    A_POL:    rexp = m_pol;
                    A_STATUS: rexp = m_st;
                    A_BOTH:   rexp = m_both;
                    default:  rexp = '0;
                endcase
            end
            ev  = ref_event(cur, prv, m_type, m_pol, m_both);
            clr = (op == 1 && a == A_STATUS) ? d : '0;
            m_st = (m_st & ~clr) | (ev & m_dir);
            if (op == 1) begin
                case (a)
                    A_DIR:  m_dir  = d;
                    A_OE:   m_oe   = d;
                    A_OUT:  m_out  = d;
                    A_MASK: m_mask = d;
                    A_TYPE: m_type = d;
                    A_POL:  m_pol  = d;
                    A_BOTH: m_both = d;
                    default: ;
                endcase
            end
            @(negedge pclk7);
            write = 1'b0; read = 1'b0;
            chk($sformatf("rnd%0d_int", k), interrupt7, m_st & m_mask);
            chk($sformatf("rnd%0d_irq_any", k), W'(irq_any7), W'(|(m_st & m_mask)));
            chk($sformatf("rnd%0d_rdata", k), rdata7, rexp);
            chk($sformatf("rnd%0d_oe_n", k), pin_oe_n7, ~(m_oe & ~m_dir) | tse);
            chk($sformatf("rnd%0d_out", k), pin_out7, m_out);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
